// File: rtl/alu_seq_ctrl_if.sv
// Request / ALU / response bundle for alu_seq_ctrl.
// The controller uses the slave view; the requester/ALU side uses the master view.
interface alu_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       alu_opcode;
  logic             alu_exec;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_hi;
  logic [WIDTH-1:0] rsp_lo;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_opcode, alu_exec, alu_a, alu_b,
           rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_opcode, alu_exec, alu_a, alu_b,
           rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer in front of a combinational ALU: one-cycle ALU ops, internal ADD/SUB,
// 32-step Booth multiply and 32-step signed restoring divide.
module alu_seq_ctrl #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFFFFFF
) (
  input logic           clock,
  input logic           clear,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic             work_bit_q, work_bit_d;
  logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
  logic             rsp_err_q, rsp_err_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   a_sext, booth_sum, div_rem;
  logic             div_ge;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             step_bit;

  always_ff @(posedge clock) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (bus.req_opcode == OP_MUL)      state_d = ITER;
        else if (bus.req_opcode == OP_DIV) state_d = (bus.req_b == '0) ? DONE : ITER;
        else                               state_d = EXEC;
      end
      EXEC:    state_d = DONE;
      ITER:    if (cnt_q == 5'd0) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.busy       = (state_q != IDLE);
    bus.rsp_valid  = (state_q == DONE);
    bus.alu_exec   = (state_q == EXEC);
    bus.alu_opcode = op_q;
    bus.alu_a      = a_q;
    bus.alu_b      = b_q;
    bus.rsp_hi     = rsp_hi_q;
    bus.rsp_lo     = rsp_lo_q;
    bus.rsp_err    = rsp_err_q;
  end

  // One iteration step; MUL is an arithmetic-shifted {hi,lo,q-1} Booth register,
  // DIV works on magnitudes with the remainder in hi and the quotient shifting into lo.
  always_comb begin
    a_neg     = a_q[WIDTH-1];
    b_neg     = b_q[WIDTH-1];
    b_mag     = b_neg ? -b_q : b_q;
    a_sext    = {a_q[WIDTH-1], a_q};
    booth_sum = work_hi_q;
    case ({work_lo_q[0], work_bit_q})
      2'b01:   booth_sum = work_hi_q + a_sext;
      2'b10:   booth_sum = work_hi_q - a_sext;
      default: booth_sum = work_hi_q;
    endcase
    div_rem = {work_hi_q[WIDTH-1:0], work_lo_q[WIDTH-1]};
    div_ge  = (div_rem >= {1'b0, b_mag});
    if (op_q == OP_MUL) begin
      step_hi  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      step_lo  = {booth_sum[0], work_lo_q[WIDTH-1:1]};
      step_bit = work_lo_q[0];
    end else begin
      step_hi  = div_ge ? (div_rem - {1'b0, b_mag}) : div_rem;
      step_lo  = {work_lo_q[WIDTH-2:0], div_ge};
      step_bit = 1'b0;
    end
  end

  always_comb begin
    accept     = (state_q == IDLE) && bus.req_valid;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    work_hi_d  = work_hi_q;
    work_lo_d  = work_lo_q;
    work_bit_d = work_bit_q;
    rsp_hi_d   = rsp_hi_q;
    rsp_lo_d   = rsp_lo_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      op_d       = bus.req_opcode;
      a_d        = bus.req_a;
      b_d        = bus.req_b;
      cnt_d      = 5'd31;
      work_hi_d  = '0;
      work_bit_d = 1'b0;
      work_lo_d  = bus.req_b;
      if (bus.req_opcode == OP_DIV) begin
        work_lo_d = bus.req_a[WIDTH-1] ? -bus.req_a : bus.req_a;
        if (bus.req_b == '0) begin
          rsp_hi_d  = bus.req_a;
          rsp_lo_d  = DIV0_LO;
          rsp_err_d = 1'b1;
        end
      end
    end else if (state_q == EXEC) begin
      rsp_hi_d  = '0;
      rsp_err_d = 1'b0;
      case (op_q)
        OP_ADD:  rsp_lo_d = a_q + b_q;
        OP_SUB:  rsp_lo_d = a_q - b_q;
        4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
                 rsp_lo_d = bus.alu_result;
        default: begin
          rsp_lo_d  = '0;
          rsp_err_d = 1'b1;
        end
      endcase
    end else if (state_q == ITER) begin
      work_hi_d  = step_hi;
      work_lo_d  = step_lo;
      work_bit_d = step_bit;
      if (cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
      end else begin
        rsp_err_d = 1'b0;
        if (op_q == OP_MUL) begin
          rsp_hi_d = step_hi[WIDTH-1:0];
          rsp_lo_d = step_lo;
        end else begin
          rsp_hi_d = a_neg ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
          rsp_lo_d = (a_neg ^ b_neg) ? -step_lo : step_lo;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      work_bit_q <= 1'b0;
      rsp_hi_q   <= '0;
      rsp_lo_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      work_hi_q  <= work_hi_d;
      work_lo_q  <= work_lo_d;
      work_bit_q <= work_bit_d;
      rsp_hi_q   <= rsp_hi_d;
      rsp_lo_q   <= rsp_lo_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural model of the
// external combinational ALU.
module tb_alu_seq_ctrl;

  logic clock;
  logic clear;
  int   checks;
  int   errors;

  alu_seq_ctrl_if #(.WIDTH(32)) bus_if ();

  alu_seq_ctrl #(.WIDTH(32), .DIV0_LO(32'hFFFFFFFF)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The external ALU; a marker value outside alu_exec exposes sampling at the wrong time.
  logic [4:0]  sh;
  logic [63:0] rot_l, rot_r;
  always_comb begin
    sh    = bus_if.alu_b[4:0];
    rot_l = {bus_if.alu_a, bus_if.alu_a} << sh;
    rot_r = {bus_if.alu_a, bus_if.alu_a} >> sh;
    bus_if.alu_result = 32'hDEADBEEF;
    if (bus_if.alu_exec) begin
      case (bus_if.alu_opcode)
        4'd2:    bus_if.alu_result = bus_if.alu_a & bus_if.alu_b;
        4'd3:    bus_if.alu_result = bus_if.alu_a | bus_if.alu_b;
        4'd4:    bus_if.alu_result = -bus_if.alu_a;
        4'd5:    bus_if.alu_result = ~bus_if.alu_a;
        4'd6:    bus_if.alu_result = bus_if.alu_a >> sh;
        4'd7:    bus_if.alu_result = $signed(bus_if.alu_a) >>> sh;
        4'd8:    bus_if.alu_result = bus_if.alu_a << sh;
        4'd9:    bus_if.alu_result = rot_r[31:0];
        4'd10:   bus_if.alu_result = rot_l[63:32];
        default: bus_if.alu_result = 32'hA5A5A5A5;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one request and returns right after the accept edge, scrambling the
  // request fields so later changes while busy would show up in the result.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (!bus_if.req_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!bus_if.req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_ready: req_ready=%0b required 1", bus_if.req_ready);
    end
    bus_if.req_valid  = 1'b1;
    bus_if.req_opcode = op;
    bus_if.req_a      = a;
    bus_if.req_b      = b;
    tick();
    bus_if.req_valid  = 1'b0;
    bus_if.req_opcode = 4'($urandom_range(0, 15));
    bus_if.req_a      = $urandom;
    bus_if.req_b      = $urandom;
  endtask

  // Waits for rsp_valid; lat counts edges from accept to the edge that samples it high.
  task automatic wait_rsp(output int lat, output int exec_cycles);
    lat = 1;
    exec_cycles = 0;
    while (!bus_if.rsp_valid && lat < 100) begin
      if (bus_if.alu_exec) exec_cycles++;
      tick();
      lat++;
    end
    if (!bus_if.rsp_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid=%0b required 1", bus_if.rsp_valid);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    checks++;
    if (bus_if.req_ready !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ready/busy/valid=%b%b%b required 100",
               bus_if.req_ready, bus_if.busy, bus_if.rsp_valid);
    end
    checks++;
    if (bus_if.rsp_err !== 1'b0 || bus_if.alu_exec !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: err/exec=%b%b required 00", bus_if.rsp_err, bus_if.alu_exec);
    end
    checks++;
    if ({bus_if.rsp_hi, bus_if.rsp_lo} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got %h_%h required 0", bus_if.rsp_hi, bus_if.rsp_lo);
    end
    checks++;
    if ({bus_if.alu_opcode, bus_if.alu_a, bus_if.alu_b} !== 68'h0) begin
      errors++;
      $display("[TB] FAIL reset_alu: op=%h a=%h b=%h required 0",
               bus_if.alu_opcode, bus_if.alu_a, bus_if.alu_b);
    end
  endtask

  task automatic test_and();
    int lat, ex;
    bus_if.rsp_ready = 1'b1;
    issue(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0);
    wait_rsp(lat, ex);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL and_latency: got %0d required 2", lat);
    end
    checks++;
    if (ex !== 1) begin
      errors++;
      $display("[TB] FAIL and_exec_cycles: got %0d required 1", ex);
    end
    checks++;
    if (bus_if.rsp_lo !== 32'h00F000F0 || bus_if.rsp_hi !== 32'h0 || bus_if.rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL and_result: got %h_%h err %b required 00000000_00f000f0 err 0",
               bus_if.rsp_hi, bus_if.rsp_lo, bus_if.rsp_err);
    end
    tick();
    checks++;
    if (bus_if.req_ready !== 1'b1 || bus_if.alu_exec !== 1'b0 || bus_if.alu_opcode !== 4'd2 ||
        bus_if.alu_a !== 32'hF0F0F0F0) begin
      errors++;
      $display("[TB] FAIL and_idle_hold: ready=%b exec=%b op=%h a=%h required 1 0 2 f0f0f0f0",
               bus_if.req_ready, bus_if.alu_exec, bus_if.alu_opcode, bus_if.alu_a);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops  [6] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd4, 4'd5};
    logic [31:0] as   [6] = '{32'h80000000, 32'h80000000, 32'h00000003, 32'h00000001, 32'h00000001, 32'h12345678};
    logic [31:0] bs   [6] = '{32'd4, 32'd4, 32'd31, 32'd1, 32'd0, 32'd0};
    logic [31:0] exps [6] = '{32'h08000000, 32'hF8000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hEDCBA987};
    int lat, ex;
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_rsp(lat, ex);
      checks++;
      if (bus_if.rsp_lo !== exps[i] || bus_if.rsp_hi !== 32'h0 || lat !== 2) begin
        errors++;
        $display("[TB] FAIL alu_op_%0d: got %h_%h lat %0d required 00000000_%h lat 2",
                 ops[i], bus_if.rsp_hi, bus_if.rsp_lo, lat, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_mul();
    logic [31:0] as [3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs [3] = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [63:0] ps [3] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h00000000_00000001};
    int lat, ex;
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(4'd11, as[i], bs[i]);
      wait_rsp(lat, ex);
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("[TB] FAIL mul_latency_%0d: got %0d required 33", i, lat);
      end
      checks++;
      if ({bus_if.rsp_hi, bus_if.rsp_lo} !== ps[i] || bus_if.rsp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mul_product_%0d: got %h_%h err %b required %h err 0",
                 i, bus_if.rsp_hi, bus_if.rsp_lo, bus_if.rsp_err, ps[i]);
      end
      tick();
    end
  endtask

  task automatic test_div();
    int lat, ex;
    bus_if.rsp_ready = 1'b1;
    issue(4'd12, 32'hFFFFFFF9, 32'd2);
    wait_rsp(lat, ex);
    checks++;
    if (bus_if.rsp_lo !== 32'hFFFFFFFD || bus_if.rsp_hi !== 32'hFFFFFFFF || lat !== 33) begin
      errors++;
      $display("[TB] FAIL div_neg_a: got %h_%h lat %0d required ffffffff_fffffffd lat 33",
               bus_if.rsp_hi, bus_if.rsp_lo, lat);
    end
    tick();
    issue(4'd12, 32'd7, 32'hFFFFFFFE);
    wait_rsp(lat, ex);
    checks++;
    if (bus_if.rsp_lo !== 32'hFFFFFFFD || bus_if.rsp_hi !== 32'h00000001 || bus_if.rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_neg_b: got %h_%h err %b required 00000001_fffffffd err 0",
               bus_if.rsp_hi, bus_if.rsp_lo, bus_if.rsp_err);
    end
    tick();
    issue(4'd12, 32'd5, 32'd0);
    wait_rsp(lat, ex);
    checks++;
    if (bus_if.rsp_err !== 1'b1 || bus_if.rsp_hi !== 32'd5 || bus_if.rsp_lo !== 32'hFFFFFFFF || lat !== 1) begin
      errors++;
      $display("[TB] FAIL div_by_zero: got err %b %h_%h lat %0d required err 1 00000005_ffffffff lat 1",
               bus_if.rsp_err, bus_if.rsp_hi, bus_if.rsp_lo, lat);
    end
    tick();
  endtask

  task automatic test_add_stall();
    int lat, ex;
    int bad;
    bus_if.rsp_ready = 1'b0;
    issue(4'd0, 32'hFFFFFFFF, 32'd1);
    wait_rsp(lat, ex);
    bus_if.req_valid  = 1'b1;
    bus_if.req_opcode = 4'd3;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_lo !== 32'h0 || bus_if.rsp_hi !== 32'h0 ||
          bus_if.req_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || lat !== 2) begin
      errors++;
      $display("[TB] FAIL add_stall_hold: bad cycles %0d lat %0d lo %h required 0 2 00000000",
               bad, lat, bus_if.rsp_lo);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.req_valid = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_release: busy=%b ready=%b valid=%b required 0 1 0",
               bus_if.busy, bus_if.req_ready, bus_if.rsp_valid);
    end
    issue(4'd1, 32'd0, 32'd1);
    wait_rsp(lat, ex);
    checks++;
    if (bus_if.rsp_lo !== 32'hFFFFFFFF || bus_if.rsp_hi !== 32'h0 || ex !== 1) begin
      errors++;
      $display("[TB] FAIL sub_wrap: got %h_%h exec %0d required 00000000_ffffffff exec 1",
               bus_if.rsp_hi, bus_if.rsp_lo, ex);
    end
    tick();
  endtask

  task automatic test_clear_mid_iter();
    int lat, ex;
    bus_if.rsp_ready = 1'b1;
    issue(4'd11, 32'hFFFFFFFD, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    clear             = 1'b1;
    bus_if.req_valid  = 1'b1;
    bus_if.req_opcode = 4'd2;
    tick();
    clear            = 1'b0;
    bus_if.req_valid = 1'b0;
    checks++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b1 || bus_if.busy !== 1'b0 ||
        bus_if.alu_opcode !== 4'd0) begin
      errors++;
      $display("[TB] FAIL clear_iter: valid=%b ready=%b busy=%b op=%h required 0 1 0 0",
               bus_if.rsp_valid, bus_if.req_ready, bus_if.busy, bus_if.alu_opcode);
    end
    issue(4'd10, 32'h80000001, 32'd1);
    wait_rsp(lat, ex);
    checks++;
    if (bus_if.rsp_lo !== 32'h00000003 || bus_if.rsp_hi !== 32'h0 || lat !== 2) begin
      errors++;
      $display("[TB] FAIL rol_after_clear: got %h_%h lat %0d required 00000000_00000003 lat 2",
               bus_if.rsp_hi, bus_if.rsp_lo, lat);
    end
    tick();
    bus_if.rsp_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd2);
    wait_rsp(lat, ex);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.rsp_lo !== 32'h0 || bus_if.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_done: valid=%b lo=%h ready=%b required 0 00000000 1",
               bus_if.rsp_valid, bus_if.rsp_lo, bus_if.req_ready);
    end
  endtask

  task automatic test_illegal();
    int lat, ex;
    bus_if.rsp_ready = 1'b1;
    issue(4'd14, 32'h12345678, 32'h9ABCDEF0);
    wait_rsp(lat, ex);
    checks++;
    if (bus_if.rsp_err !== 1'b1 || bus_if.rsp_hi !== 32'h0 || bus_if.rsp_lo !== 32'h0 ||
        ex !== 1 || lat !== 2) begin
      errors++;
      $display("[TB] FAIL illegal_op: err %b %h_%h exec %0d lat %0d required err 1 0_0 exec 1 lat 2",
               bus_if.rsp_err, bus_if.rsp_hi, bus_if.rsp_lo, ex, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int accepts, rsps, bad;
    bus_if.rsp_ready  = 1'b1;
    bus_if.req_valid  = 1'b1;
    bus_if.req_opcode = 4'd3;
    bus_if.req_a      = 32'h0000FF00;
    bus_if.req_b      = 32'h00F0000F;
    accepts = 0;
    rsps    = 0;
    bad     = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus_if.req_ready) accepts++;
      if (bus_if.rsp_valid) begin
        rsps++;
        if (bus_if.rsp_lo !== 32'h00F0FF0F) bad++;
      end
      tick();
    end
    bus_if.req_valid = 1'b0;
    checks++;
    if (accepts !== 3 || rsps !== 3 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL back_to_back: accepts %0d rsps %0d bad %0d required 3 3 0",
               accepts, rsps, bad);
    end
    tick();
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    clear             = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_opcode = 4'd0;
    bus_if.req_a      = 32'h0;
    bus_if.req_b      = 32'h0;
    bus_if.rsp_ready  = 1'b0;
    test_reset();
    test_and();
    test_alu_ops();
    test_mul();
    test_div();
    test_add_stall();
    test_clear_mid_iter();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
